pyramic_adc_clk_gen: RTL and testbench
======================================

# pyramic_adc_clk_gen

Sits directly downstream of the 50→48 MHz array PLL and consumes its 48 MHz output clock and `locked` flag. Qualifies `locked` as stable and holds the microphone ADCs in reset until then. Once released, it generates the ADC serial bit clock (`sclk`) and frame clock (`lrck`) with a fixed, reset-defined phase. It also emits single-cycle edge and frame strobes that the downstream deserializer uses to sample ADC data without crossing clock domains.

## Interface
Parameters:
- `SCLK_HALF`, default 8: `clk` cycles per `sclk` half-period. ≥2. Default gives 3 MHz.
- `FRAME_BITS`, default 64: `sclk` periods per `lrck` frame. Power of 2, ≥4. Default gives 46.875 kHz.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before release. ≥1.

Ports:
- `clk`: in, 1. PLL `outclk_0`, 48 MHz.
- `rst`: in, 1. Reset, synchronous to `clk`, active-high.
- `pll_locked`: in, 1. PLL `locked`; asynchronous to `clk`.
- `adc_rst_n`: out, 1. ADC reset, active-low; high only in RUN.
- `clk_ready`: out, 1. High in RUN.
- `sclk`: out, 1. ADC bit clock.
- `lrck`: out, 1. ADC frame clock; 0 = left half of frame.
- `sclk_rise`: out, 1. High in the first `clk` cycle in which `sclk` = 1.
- `sclk_fall`: out, 1. High in the first `clk` cycle in which `sclk` = 0 after a high phase.
- `frame_start`: out, 1. High in the cycle `bit_idx` becomes 0.
- `bit_idx`: out, log2(FRAME_BITS). Current bit within the frame.
- `lock_loss_cnt`: out, 16. Saturating count of lock losses while in RUN; see Configuration.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`; latency 2 cycles.
- FSM states:
  - WAIT_LOCK (reset state): `stab_cnt` = 0. Moves to STABILIZE when `lock_s` = 1.
  - STABILIZE: `stab_cnt` increments each cycle. Returns to WAIT_LOCK when `lock_s` = 0, clearing the counter. Moves to RUN when `lock_s` = 1 and `stab_cnt` = LOCK_STABLE_CYCLES−1.
  - RUN: returns to WAIT_LOCK when `lock_s` = 0. All clock outputs are forced to 0 and `adc_rst_n` to 0 in the cycle after `lock_s` falls.
- Outside RUN: `sclk`, `lrck`, all strobes and `bit_idx` are 0; `div_cnt` = 0.
- In RUN, `div_cnt` counts 0..SCLK_HALF−1 and wraps.
  - On wrap, `sclk` toggles.
  - On a 1→0 toggle, `bit_idx` increments modulo FRAME_BITS.
  - `lrck` = (`bit_idx` ≥ FRAME_BITS/2). It therefore changes only coincident with `sclk` falling, as I2S requires.
- `frame_start`:
  - high in the first RUN cycle;
  - thereafter high in every cycle where `bit_idx` wraps from FRAME_BITS−1 to 0.
- All outputs are registered. No combinational path from `pll_locked` to any output.
- `rst` has priority over everything. Asserting it mid-RUN truncates the frame; no partial-frame flush is performed.

## Timing
- Reset values: state WAIT_LOCK; all outputs 0, including `adc_rst_n` = 0 and `lock_loss_cnt` = 0; synchronizer flops 0.
- Startup: `pll_locked` rises at cycle 0 → `lock_s` at cycle 2 → RUN entry at cycle 2+LOCK_STABLE_CYCLES. With defaults, `clk_ready`, `adc_rst_n` and `frame_start` are all high at cycle 1026.
- Edge schedule, with t0 = RUN entry:
  - `sclk` rises at t0+SCLK_HALF;
  - `sclk` falls at t0+2·SCLK_HALF, with `bit_idx` = 1;
  - `lrck` rises at t0+SCLK_HALF·FRAME_BITS (512 with defaults);
  - next `frame_start` at t0+2·SCLK_HALF·FRAME_BITS (1024 with defaults).
- Strobes are exactly one cycle wide. `sclk_fall` and `frame_start` coincide on frame wrap.
- Lock loss in RUN: `lock_s` = 0 at cycle t → at t+1, state WAIT_LOCK and all clock outputs and `adc_rst_n` = 0.

## Configuration
- `PYRAMIC_CLKGEN_LOSS_CNT_EN`:
  - Defined: `lock_loss_cnt` increments on each RUN→WAIT_LOCK transition and saturates at 0xFFFF. It is cleared only by `rst`.
  - Undefined: no counter logic is built; `lock_loss_cnt` is tied to 0.

## Structure
- Package `pyramic_clk_pkg` holds:
  - the state enum (WAIT_LOCK, STABILIZE, RUN);
  - default constants for SCLK_HALF, FRAME_BITS and LOCK_STABLE_CYCLES;
  - the `lock_loss_cnt` width constant (16).
- One sub-module: `pyramic_sync2`, the generic 2-flop synchronizer with synchronous reset, used for `pll_locked`.

## Test plan
- Reset, then `pll_locked` = 1 at cycle 10 (defaults) → RUN, `clk_ready`, `adc_rst_n` = 1 and `frame_start` = 1 at cycle 1036. No output toggles before that.
- `pll_locked` glitches low for 3 cycles at stabilize count 500 → FSM returns to WAIT_LOCK; release occurs 1024 cycles after the re-synchronized rise, not before.
- Steady RUN for 3 frames → `sclk` period exactly 16 cycles, 50% duty; `lrck` period 1024 cycles, high for 512; `lrck` changes only in cycles with `sclk_fall` = 1; `bit_idx` sequence 0..63 repeating.
- Drop `pll_locked` mid-frame at `bit_idx` = 40 → 3 cycles later `sclk`, `lrck`, `bit_idx` and `adc_rst_n` are 0. With the macro defined, `lock_loss_cnt` = 1.
- Assert `rst` for 1 cycle in RUN → next cycle all outputs 0 and state WAIT_LOCK. With `pll_locked` held high, RUN is re-entered 1026 cycles later with `bit_idx` = 0.
- SCLK_HALF = 2, FRAME_BITS = 4, LOCK_STABLE_CYCLES = 1 → `sclk` period 4 cycles, frame length 16 cycles, RUN 3 cycles after `pll_locked` rises.

Source files
------------

// File: rtl/pyramic_clk_pkg.sv
// Shared types and defaults for the Pyramic ADC clock generator.
package pyramic_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  localparam int SCLK_HALF_DEF          = 8;
  localparam int FRAME_BITS_DEF         = 64;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int LOSS_CNT_W             = 16;

endpackage

// File: rtl/pyramic_sync2.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module pyramic_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/pyramic_adc_clk_gen.sv
// ADC bit/frame clock generator gated on a qualified PLL lock.
// Optional lock-loss counter: define PYRAMIC_CLKGEN_LOSS_CNT_EN.
module pyramic_adc_clk_gen
  import pyramic_clk_pkg::*;
#(
  parameter int SCLK_HALF          = SCLK_HALF_DEF,
  parameter int FRAME_BITS         = FRAME_BITS_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pll_locked,
  output logic                          adc_rst_n,
  output logic                          clk_ready,
  output logic                          sclk,
  output logic                          lrck,
  output logic                          sclk_rise,
  output logic                          sclk_fall,
  output logic                          frame_start,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic [LOSS_CNT_W-1:0]         lock_loss_cnt
);

  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam int DIV_W  = $clog2(SCLK_HALF);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);

  logic lock_s;

  pyramic_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  clk_state_e        state, state_nxt;
  logic [STAB_W-1:0] stab_cnt, stab_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_nxt;
  logic              sclk_nxt, rise_nxt, fall_nxt, fs_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_LOCK;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = '0;
    unique case (state)
      WAIT_LOCK: if (lock_s) state_nxt = STABILIZE;
      STABILIZE: begin
        if (!lock_s)                    state_nxt = WAIT_LOCK;
        else if (stab_cnt == STAB_LAST) state_nxt = RUN;
        else                            stab_nxt  = stab_cnt + STAB_W'(1);
      end
      RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // Divider and frame position; the first RUN cycle starts a fresh frame.
  always_comb begin
    div_nxt  = '0;
    sclk_nxt = 1'b0;
    bit_nxt  = '0;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    fs_nxt   = 1'b0;
    if (state_nxt == RUN) begin
      if (state != RUN) begin
        fs_nxt = 1'b1;
      end else begin
        sclk_nxt = sclk;
        bit_nxt  = bit_idx;
        if (div_cnt == DIV_LAST) begin
          sclk_nxt = ~sclk;
          if (sclk) begin
            bit_nxt  = bit_idx + BIT_W'(1);
            fall_nxt = 1'b1;
            fs_nxt   = (bit_idx == BIT_LAST);
          end else begin
            rise_nxt = 1'b1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      sclk        <= 1'b0;
      lrck        <= 1'b0;
      bit_idx     <= '0;
      sclk_rise   <= 1'b0;
      sclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      adc_rst_n   <= 1'b0;
      clk_ready   <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      sclk        <= sclk_nxt;
      lrck        <= bit_nxt[BIT_W-1];
      bit_idx     <= bit_nxt;
      sclk_rise   <= rise_nxt;
      sclk_fall   <= fall_nxt;
      frame_start <= fs_nxt;
      adc_rst_n   <= (state_nxt == RUN);
      clk_ready   <= (state_nxt == RUN);
    end
  end

`ifdef PYRAMIC_CLKGEN_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (state == RUN && state_nxt == WAIT_LOCK && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pyramic_adc_clk_gen.sv
// Bench for pyramic_adc_clk_gen: default and minimal parameter sets.
module tb_pyramic_adc_clk_gen;
  import pyramic_clk_pkg::*;

  localparam int H1 = 8, F1 = 64, L1 = 1024;
  localparam int H2 = 2, F2 = 4,  L2 = 1;

`ifdef PYRAMIC_CLKGEN_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, pll1 = 1'b0, rst2 = 1'b1, pll2 = 1'b0;
  logic adc1, rdy1, sclk1, lrck1, rise1, fall1, fs1;
  logic adc2, rdy2, sclk2, lrck2, rise2, fall2, fs2;
  logic [5:0]  bidx1;
  logic [1:0]  bidx2;
  logic [15:0] loss1, loss2;

  pyramic_adc_clk_gen u_dut1 (
    .clk(clk), .rst(rst1), .pll_locked(pll1), .adc_rst_n(adc1), .clk_ready(rdy1),
    .sclk(sclk1), .lrck(lrck1), .sclk_rise(rise1), .sclk_fall(fall1),
    .frame_start(fs1), .bit_idx(bidx1), .lock_loss_cnt(loss1)
  );

  pyramic_adc_clk_gen #(.SCLK_HALF(H2), .FRAME_BITS(F2), .LOCK_STABLE_CYCLES(L2)) u_dut2 (
    .clk(clk), .rst(rst2), .pll_locked(pll2), .adc_rst_n(adc2), .clk_ready(rdy2),
    .sclk(sclk2), .lrck(lrck2), .sclk_rise(rise2), .sclk_fall(fall2),
    .frame_start(fs2), .bit_idx(bidx2), .lock_loss_cnt(loss2)
  );

  typedef struct packed {
    logic adc, rdy, sclk, lrck, rise, fall, fs;
    logic [7:0]  bidx;
    logic [15:0] loss;
  } obs_t;

  typedef struct {
    int   off;
    obs_t exp;
  } vec_t;

  // Reference: lock_s is pll_locked two edges late; RUN holds once it has been
  // sampled high on L+1 consecutive edges; outputs follow from time in RUN.
  typedef struct packed {
    logic d1, d2;
    int   hi;
    logic run;
    int   t;
    int   loss;
  } mdl_t;

  int   checks = 0, errors = 0;
  logic chk_en = 1'b0, done2 = 1'b0;
  mdl_t m1 = '0, m2 = '0;
  obs_t obs1, obs2;

  assign obs1 = {adc1, rdy1, sclk1, lrck1, rise1, fall1, fs1, 8'(bidx1), loss1};
  assign obs2 = {adc2, rdy2, sclk2, lrck2, rise2, fall2, fs2, 8'(bidx2), loss2};

  function automatic mdl_t mstep(mdl_t m, logic r, logic p, int l);
    mdl_t n = m;
    logic ls;
    if (r) return '0;
    ls   = m.d2;
    n.d2 = m.d1;
    n.d1 = p;
    n.hi = ls ? m.hi + 1 : 0;
    n.run = (n.hi >= l + 1);
    if (LOSS_EN && m.run && !n.run && m.loss < 65535) n.loss = m.loss + 1;
    n.t = (m.run && n.run) ? m.t + 1 : 0;
    return n;
  endfunction

  function automatic obs_t expect_obs(mdl_t m, int h, int f);
    obs_t o = '0;
    int ph, b;
    o.loss = 16'(m.loss);
    if (m.run) begin
      ph     = m.t % (2 * h);
      b      = (m.t / (2 * h)) % f;
      o.adc  = 1'b1;
      o.rdy  = 1'b1;
      o.sclk = (ph >= h);
      o.rise = (ph == h);
      o.fall = (ph == 0) && (m.t > 0);
      o.bidx = 8'(b);
      o.lrck = (b >= f / 2);
      o.fs   = (m.t % (2 * h * f)) == 0;
    end
    return o;
  endfunction

  function automatic obs_t mk(logic a, logic r, logic s, logic l, logic ri, logic fa,
                              logic f, int b);
    obs_t o = '0;
    o.adc = a; o.rdy = r; o.sclk = s; o.lrck = l;
    o.rise = ri; o.fall = fa; o.fs = f; o.bidx = 8'(b);
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_rdy1(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!rdy1 && n < 5000);
  endtask

  always @(posedge clk) begin
    m1 <= mstep(m1, rst1, pll1, L1);
    m2 <= mstep(m2, rst2, pll2, L2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_obs("model_dut1", obs1, expect_obs(m1, H1, F1));
      check_obs("model_dut2", obs2, expect_obs(m2, H2, F2));
    end
  end

  initial begin
    vec_t tbl[12];
    obs_t e;
    int k, n, hi_s, hi_l, nr, nfs, nchg, bad_l, bad_gap, last_r;
    logic prev_l;

    tbl[0]  = '{1025, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1026, mk(1, 1, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1027, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1033, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1034, mk(1, 1, 1, 0, 1, 0, 0, 0)};
    tbl[5]  = '{1035, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1042, mk(1, 1, 0, 0, 0, 1, 0, 1)};
    tbl[7]  = '{1537, mk(1, 1, 1, 0, 0, 0, 0, 31)};
    tbl[8]  = '{1538, mk(1, 1, 0, 1, 0, 1, 0, 32)};
    tbl[9]  = '{2049, mk(1, 1, 1, 1, 0, 0, 0, 63)};
    tbl[10] = '{2050, mk(1, 1, 0, 0, 0, 1, 1, 0)};
    tbl[11] = '{2051, mk(1, 1, 0, 0, 0, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #2 rst1 = 1'b0;
    chk_en = 1'b1;
    repeat (9) @(posedge clk);
    #2 pll1 = 1'b1;

    // Offsets count edges from the one that first captures pll_locked high.
    k = -1;
    for (int i = 0; i < 12; i++) begin
      while (k < tbl[i].off) begin
        @(posedge clk); k++;
      end
      @(negedge clk);
      check_obs($sformatf("startup_vec%0d", i), obs1, tbl[i].exp);
    end

    hi_s = 0; hi_l = 0; nr = 0; nfs = 0; nchg = 0; bad_l = 0; bad_gap = 0;
    last_r = -1; prev_l = lrck1;
    for (int c = 0; c < 3 * 2 * H1 * F1; c++) begin
      @(posedge clk); @(negedge clk);
      hi_s += int'(sclk1);
      hi_l += int'(lrck1);
      if (rise1) begin
        if (last_r >= 0 && c - last_r != 2 * H1) bad_gap++;
        last_r = c; nr++;
      end
      if (fs1) nfs++;
      if (lrck1 != prev_l) begin
        nchg++;
        if (!fall1) bad_l++;
      end
      prev_l = lrck1;
    end
    check_int("steady_sclk_high", hi_s, 3 * H1 * F1);
    check_int("steady_lrck_high", hi_l, 3 * H1 * F1);
    check_int("steady_sclk_rises", nr, 3 * F1);
    check_int("steady_sclk_period", bad_gap, 0);
    check_int("steady_frames", nfs, 3);
    check_int("steady_lrck_edges", nchg, 6);
    check_int("steady_lrck_off_fall", bad_l, 0);

    n = 0;
    while (bidx1 != 6'd40 && n < 3000) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_int("drop_found_bit40", int'(bidx1), 40);
    pll1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_int("drop_t2_still_ready", int'(rdy1), 1);
    @(posedge clk); @(negedge clk);
    e = mk(0, 0, 0, 0, 0, 0, 0, 0);
    e.loss = 16'(LOSS_EN);
    check_obs("drop_t3_outputs", obs1, e);

    pll1 = 1'b1;
    repeat (503) @(posedge clk);
    @(negedge clk);
    pll1 = 1'b0;
    repeat (3) @(negedge clk);
    pll1 = 1'b1;
    wait_rdy1(n);
    check_int("glitch_release_latency", n, 3 + L1);

    repeat (100) @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst1 = 1'b0;
    check_obs("rst_mid_run", obs1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    wait_rdy1(n);
    check_int("rst_reentry_latency", n, 3 + L1);
    check_int("rst_reentry_bit_idx", int'(bidx1), 0);
    check_int("rst_reentry_frame_start", int'(fs1), 1);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(100, 1400)) @(negedge clk);
      pll1 = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      pll1 = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
      end
    end

    wait (done2);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n, c;
    repeat (3) @(posedge clk);
    #2 rst2 = 1'b0;
    repeat (5) @(negedge clk);
    pll2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!rdy2 && n < 100);
    check_int("small_run_latency", n, 3 + L2);
    check_int("small_entry_frame_start", int'(fs2), 1);

    c = 0;
    do begin
      @(posedge clk); @(negedge clk); c++;
    end while (!fs2 && c < 100);
    check_int("small_frame_len", c, 2 * H2 * F2);

    c = 0;
    while (!rise2 && c < 100) begin
      @(posedge clk); @(negedge clk); c++;
    end
    c = 0;
    do begin
      @(posedge clk); @(negedge clk); c++;
    end while (!rise2 && c < 100);
    check_int("small_sclk_period", c, 2 * H2);

    for (int r = 0; r < 300; r++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      pll2 = ~pll2;
      if ($urandom_range(0, 15) == 0) begin
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
      end
    end
    done2 = 1'b1;
  end

endmodule
